dbus_initiator: RTL and testbench

DBUS_INITIATOR -- requirements
Module: dbus_initiator

---
 rtl/dbus_initiator.sv | 166 ++++++++++++++++
 tb/tb_dbus_initiator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_initiator.sv
// Data-bus initiator: turns one core command into one or two 32-bit req/ack
// word phases on the peripheral bus, with a per-phase ack timeout.
package dbus_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] w_data;
        logic        w_en;
    } type_dbus2peri_s;

    typedef struct packed {
        logic        ack;
        logic [31:0] r_data;
    } type_peri2dbus_s;
endpackage

module dbus_initiator
    import dbus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [31:0]     cmd_addr_i,
    input  logic            cmd_wen_i,
    input  logic            cmd_dword_i,
    input  logic [63:0]     cmd_wdata_i,
    output logic            rsp_valid_o,
    output logic [63:0]     rsp_rdata_o,
    output logic            rsp_err_o,
    output type_dbus2peri_s dbus2peri_o,
    input  type_peri2dbus_s peri2dbus_i,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_LO = 3'd1,
        GAP    = 3'd2,
        REQ_HI = 3'd3,
        RESP   = 3'd4
    } state_e;

    // Abort fires in the cycle the counter would reach TIMEOUT_CYCLES.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e          state;
    state_e          state_next;
    logic [7:0]      wait_cnt;
    type_dbus2peri_s bus_q;
    logic            dword_q;
    logic [31:0]     wdata_hi_q;
    logic [63:0]     rdata_q;
    logic            err_q;

    logic            accept;
    logic            in_phase;
    logic            ack_ok;
    logic            abort;

    // Handshake: a command transfers on a clk edge where cmd_valid_i && cmd_ready_o;
    // ready is high only in IDLE and never depends on valid. The response is a
    // single-cycle rsp_valid_o pulse with no ready, so the consumer must take it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = REQ_LO;
            REQ_LO: begin
                if (ack_ok)     state_next = dword_q ? GAP : RESP;
                else if (abort) state_next = RESP;
            end
            GAP:     state_next = REQ_HI;
            REQ_HI:  if (ack_ok || abort) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ack in the first cycle of a phase (wait_cnt == 0) is not trusted.
    always_comb begin
        cmd_ready_o = (state == IDLE) && rst_n;
        rsp_valid_o = (state == RESP);
        accept      = cmd_valid_i && cmd_ready_o;
        in_phase    = (state == REQ_LO) || (state == REQ_HI);
        ack_ok      = in_phase && peri2dbus_i.ack && (wait_cnt != 8'd0);
        abort       = in_phase && !ack_ok && (wait_cnt == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (accept || state == GAP) begin
            wait_cnt <= 8'd0;
        end else if (in_phase && !ack_ok) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_q      <= '0;
            dword_q    <= 1'b0;
            wdata_hi_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus_q.req    <= 1'b1;
                        bus_q.addr   <= cmd_addr_i & 32'hFFFF_FFFC;
                        bus_q.w_data <= cmd_wdata_i[31:0];
                        bus_q.w_en   <= cmd_wen_i;
                        dword_q      <= cmd_dword_i;
                        wdata_hi_q   <= cmd_wdata_i[63:32];
                        rdata_q      <= '0;
                        err_q        <= 1'b0;
                    end
                end
                REQ_LO: begin
                    if (ack_ok) begin
                        bus_q.req <= 1'b0;
                        if (!bus_q.w_en) rdata_q[31:0] <= peri2dbus_i.r_data;
                    end else if (abort) begin
                        bus_q.req <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                    end
                end
                GAP: begin
                    // High word address wraps naturally in 32 bits.
                    bus_q.req    <= 1'b1;
                    bus_q.addr   <= bus_q.addr + 32'd4;
                    bus_q.w_data <= wdata_hi_q;
                end
                REQ_HI: begin
                    if (ack_ok) begin
                        bus_q.req <= 1'b0;
                        if (!bus_q.w_en) rdata_q[63:32] <= peri2dbus_i.r_data;
                    end else if (abort) begin
                        bus_q.req <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbus2peri_o = bus_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_dbus_initiator.sv
// Directed + randomized bench for dbus_initiator against a behavioural
// responder and a transaction-level expectation model.
module tb_dbus_initiator;
    import dbus_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid, cmd_valid_to;
    logic            cmd_ready, cmd_ready_to;
    logic [31:0]     cmd_addr;
    logic            cmd_wen;
    logic            cmd_dword;
    logic [63:0]     cmd_wdata;
    logic            rsp_valid, rsp_valid_to;
    logic [63:0]     rsp_rdata, rsp_rdata_to;
    logic            rsp_err, rsp_err_to;
    type_dbus2peri_s dbus, dbus_to;
    type_peri2dbus_s peri, peri_to;
    logic [2:0]      dbg_state, dbg_state_to;

    int n_tests = 0;
    int n_fail  = 0;

    logic [64:0] exp_q[$];
    logic [64:0] obs_q[$];
    logic [31:0] mem [logic [31:0]];

    int   resp_delay = 1;
    logic stray_en   = 1'b0;
    int   rises      = 0;
    int   rsp_cnt    = 0;

    dbus_initiator u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_wen_i(cmd_wen), .cmd_dword_i(cmd_dword),
        .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .dbus2peri_o(dbus), .peri2dbus_i(peri), .dbg_state(dbg_state)
    );

    dbus_initiator #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_to), .cmd_ready_o(cmd_ready_to),
        .cmd_addr_i(cmd_addr), .cmd_wen_i(cmd_wen), .cmd_dword_i(cmd_dword),
        .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid_to), .rsp_rdata_o(rsp_rdata_to), .rsp_err_o(rsp_err_to),
        .dbus2peri_o(dbus_to), .peri2dbus_i(peri_to), .dbg_state(dbg_state_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A0F};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder: acks resp_delay cycles after req rises, optionally with stray acks.
    initial begin : responder
        int   rcnt;
        logic acked;
        logic prev_req;
        rcnt = 0; acked = 1'b0; prev_req = 1'b0;
        peri = '0;
        peri_to = '0;
        forever begin
            @(posedge clk); #1;
            peri.ack       = 1'b0;
            peri.r_data    = $urandom;
            peri_to.ack    = 1'b0;
            peri_to.r_data = $urandom;
            if (rsp_valid) rsp_cnt++;
            if (!dbus.req) begin
                rcnt  = 0;
                acked = 1'b0;
                if (stray_en) peri.ack = 1'($urandom_range(0, 1));
            end else begin
                if (!prev_req) rises++;
                rcnt++;
                if (stray_en && rcnt == 1) peri.ack = 1'b1;
                if (!acked && rcnt == resp_delay + 1) begin
                    peri.ack    = 1'b1;
                    peri.r_data = rd_word(dbus.addr);
                    acked       = 1'b1;
                    obs_q.push_back({dbus.w_en, dbus.addr, dbus.w_data});
                end
            end
            prev_req = dbus.req;
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_wait", 65'(cmd_ready), 65'd1);
    endtask

    task automatic run_txn(input logic [31:0] a, input logic wen, input logic dw,
                           input logic [63:0] wd, input int d);
        logic [31:0] alo, ahi;
        logic [63:0] exp_rd;
        logic [64:0] e, o;
        int exp_lat, lat, rise0, busy_ready;
        alo = {a[31:2], 2'b00};
        ahi = alo + 32'd4;
        resp_delay = d;
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({wen, alo, wd[31:0]});
        if (dw) exp_q.push_back({wen, ahi, wd[63:32]});
        if (wen)     exp_rd = 64'd0;
        else if (dw) exp_rd = {rd_word(ahi), rd_word(alo)};
        else         exp_rd = {32'd0, rd_word(alo)};
        exp_lat = dw ? 2 * d + 4 : d + 2;

        wait_ready();
        cmd_addr = a; cmd_wen = wen; cmd_dword = dw; cmd_wdata = wd;
        cmd_valid = 1'b1;
        rise0 = rises;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr = $urandom; cmd_wen = 1'($urandom); cmd_dword = 1'($urandom);
        cmd_wdata = {$urandom, $urandom};
        lat = 1;
        busy_ready = 0;
        while (!rsp_valid && lat < 600) begin
            if (cmd_ready) busy_ready++;
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_seen", 65'(rsp_valid), 65'd1);
        chk("latency", 65'(lat), 65'(exp_lat));
        chk("rdata", 65'(rsp_rdata), 65'(exp_rd));
        chk("err", 65'(rsp_err), 65'd0);
        chk("req_low_in_resp", 65'(dbus.req), 65'd0);
        chk("ready_busy", 65'(busy_ready + int'(cmd_ready)), 65'd0);
        chk("phase_count", 65'(rises - rise0), 65'(dw ? 2 : 1));
        chk("obs_count", 65'(obs_q.size()), 65'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk("phase", o, e);
        end
        @(posedge clk); #1;
        chk("rsp_one_cycle", 65'(rsp_valid), 65'd0);
        chk("ready_after", 65'(cmd_ready), 65'd1);
        chk("rdata_hold", 65'(rsp_rdata), 65'(exp_rd));
        chk("err_hold", 65'(rsp_err), 65'd0);
    endtask

    initial begin : main
        int lat, req_cycles, rises_to, rsp_before;
        logic prev;
        logic [31:0] a;
        logic [63:0] wd;

        mem[32'h0200_BFF8] = 32'h1234_5678;
        cmd_valid = 1'b0; cmd_valid_to = 1'b0;
        cmd_addr = '0; cmd_wen = 1'b0; cmd_dword = 1'b0; cmd_wdata = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 65'(cmd_ready), 65'd0);
        chk("rst_ready_to", 65'(cmd_ready_to), 65'd0);
        chk("rst_bus", 65'({dbus.req, dbus.w_en}), 65'd0);
        chk("rst_addr", 65'(dbus.addr), 65'd0);
        chk("rst_wdata", 65'(dbus.w_data), 65'd0);
        chk("rst_rsp_valid", 65'(rsp_valid), 65'd0);
        chk("rst_rdata", 65'(rsp_rdata), 65'd0);
        chk("rst_err", 65'(rsp_err), 65'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 65'(cmd_ready), 65'd1);

        run_txn(32'h0200_BFF8, 1'b0, 1'b0, 64'd0, 1);
        run_txn(32'h0200_4000, 1'b1, 1'b1, 64'hAABB_CCDD_1122_3344, 1);
        run_txn(32'h0100_0020, 1'b0, 1'b0, 64'd0, 5);
        run_txn(32'h0100_0040, 1'b1, 1'b1, 64'h0F0F_0F0F_F0F0_F0F0, 5);
        run_txn(32'hFFFF_FFFF, 1'b0, 1'b1, 64'd0, 2);
        stray_en = 1'b1;
        run_txn(32'h0200_BFF8, 1'b0, 1'b1, 64'd0, 1);
        stray_en = 1'b0;

        // Timeout: responder on the short-timeout instance never acks.
        cmd_addr = 32'h1000_0010; cmd_wen = 1'b0; cmd_dword = 1'b1; cmd_wdata = '1;
        chk("to_ready", 65'(cmd_ready_to), 65'd1);
        cmd_valid_to = 1'b1;
        @(posedge clk); #1;
        cmd_valid_to = 1'b0;
        lat = 1; req_cycles = 0; rises_to = 0; prev = 1'b0;
        while (!rsp_valid_to && lat < 50) begin
            if (dbus_to.req) begin
                req_cycles++;
                if (!prev) rises_to++;
                chk("to_addr", 65'(dbus_to.addr), 65'h1000_0010);
            end
            prev = dbus_to.req;
            @(posedge clk); #1;
            lat++;
        end
        chk("to_rsp_seen", 65'(rsp_valid_to), 65'd1);
        chk("to_req_cycles", 65'(req_cycles), 65'd4);
        chk("to_phases", 65'(rises_to), 65'd1);
        chk("to_latency", 65'(lat), 65'd5);
        chk("to_err", 65'(rsp_err_to), 65'd1);
        chk("to_rdata", 65'(rsp_rdata_to), 65'd0);
        @(posedge clk); #1;
        chk("to_one_cycle", 65'(rsp_valid_to), 65'd0);
        chk("to_err_hold", 65'(rsp_err_to), 65'd1);
        chk("to_req_idle", 65'(dbus_to.req), 65'd0);

        // Reset during the high phase of a dword read (d=3: REQ_HI spans cycles 6..9).
        resp_delay = 3;
        wait_ready();
        cmd_addr = 32'h0300_0100; cmd_wen = 1'b0; cmd_dword = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_req_hi", 65'(dbus.req), 65'd1);
        chk("mid_addr_hi", 65'(dbus.addr), 65'h0300_0104);
        rsp_before = rsp_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_drop", 65'(dbus.req), 65'd0);
        chk("rst_ready_low", 65'(cmd_ready), 65'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("ready_first_cycle", 65'(cmd_ready), 65'd1);
        chk("rst_rdata_clr", 65'(rsp_rdata), 65'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("no_rsp_after_rst", 65'(rsp_cnt - rsp_before), 65'd0);
        chk("idle_after_rst", 65'(dbus.req), 65'd0);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            wd = {$urandom, $urandom};
            stray_en = 1'($urandom_range(0, 1));
            run_txn(a, 1'($urandom), 1'($urandom), wd, $urandom_range(1, 6));
        end
        stray_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
